// File: rtl/uart_top_module.sv
// rtl/uart_top_module.sv - 32-bit-word UART (baud tick, framed Tx, loopback Rx); UART_ODD_PARITY_EN selects odd parity
module uart_top_module #(
    parameter int CLKS_PER_BIT = 1302
) (
    input  logic        Clock_In,
    input  logic        Reset,
    input  logic [31:0] Data_In,
    input  logic        Tx_start,
    output logic        Tx_dataOut,
    output logic        Baud_Clk,
    output logic        Load,
    output logic        Shift,
    output logic        S0,
    output logic        S1,
    output logic        Data_Bit,
    output logic        Parity_Bit,
    output logic        DeStart_Bit,
    output logic        Shift1,
    output logic        Check_Stop,
    output logic        Load1,
    output logic [31:0] Rx_data,
    output logic [31:0] Rx_dataOut,
    output logic        Parity_Error,
    output logic        Stop_Error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    function automatic logic word_parity(input logic [31:0] w);
`ifdef UART_ODD_PARITY_EN
        return ~^w;
`else
        return ^w;
`endif
    endfunction

    logic [CW-1:0] baud_cnt;
    state_t        tx_state;
    logic [31:0]   tx_shreg;
    logic [4:0]    tx_bit_cnt;
    state_t        rx_state;
    logic [CW-1:0] rx_cnt;
    logic [4:0]    rx_bit_cnt;

    always_ff @(posedge Clock_In or posedge Reset) begin
        if (Reset)
            baud_cnt <= '0;
        else if (baud_cnt == LAST)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    assign Baud_Clk = (baud_cnt == LAST);
    assign Data_Bit = tx_shreg[0];

    always_ff @(posedge Clock_In or posedge Reset) begin
        if (Reset) begin
            tx_state   <= ST_IDLE;
            tx_shreg   <= '0;
            tx_bit_cnt <= '0;
            Load       <= 1'b0;
            Shift      <= 1'b0;
            S1         <= 1'b0;
            S0         <= 1'b0;
            Parity_Bit <= 1'b0;
        end else begin
            Load  <= 1'b0;
            Shift <= 1'b0;
            if (Baud_Clk) begin
                case (tx_state)
                    ST_IDLE, ST_STOP: begin
                        // STOP with Tx_start still high chains straight into the next START
                        if (Tx_start) begin
                            Load       <= 1'b1;
                            tx_shreg   <= Data_In;
                            Parity_Bit <= word_parity(Data_In);
                            {S1, S0}   <= 2'b01;
                            tx_state   <= ST_START;
                        end else begin
                            {S1, S0}   <= 2'b00;
                            tx_state   <= ST_IDLE;
                        end
                    end
                    ST_START: begin
                        {S1, S0}   <= 2'b10;
                        tx_bit_cnt <= '0;
                        tx_state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        Shift      <= 1'b1;
                        tx_shreg   <= {1'b0, tx_shreg[31:1]};
                        tx_bit_cnt <= tx_bit_cnt + 1'b1;
                        if (tx_bit_cnt == 5'd31) begin
                            {S1, S0} <= 2'b11;
                            tx_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        {S1, S0} <= 2'b00;
                        tx_state <= ST_STOP;
                    end
                    default: begin
                        {S1, S0} <= 2'b00;
                        tx_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock_In or posedge Reset) begin
        if (Reset)
            Tx_dataOut <= 1'b1;
        else begin
            case ({S1, S0})
                2'b00:   Tx_dataOut <= 1'b1;
                2'b01:   Tx_dataOut <= 1'b0;
                2'b10:   Tx_dataOut <= tx_shreg[0];
                default: Tx_dataOut <= Parity_Bit;
            endcase
        end
    end

    always_ff @(posedge Clock_In or posedge Reset) begin
        if (Reset) begin
            rx_state     <= ST_IDLE;
            rx_cnt       <= '0;
            rx_bit_cnt   <= '0;
            DeStart_Bit  <= 1'b0;
            Shift1       <= 1'b0;
            Check_Stop   <= 1'b0;
            Load1        <= 1'b0;
            Rx_data      <= '0;
            Rx_dataOut   <= '0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            DeStart_Bit <= 1'b0;
            Shift1      <= 1'b0;
            Check_Stop  <= 1'b0;
            Load1       <= 1'b0;
            if (Check_Stop) begin
                Load1      <= 1'b1;
                Rx_dataOut <= Rx_data;
            end
            case (rx_state)
                ST_IDLE: begin
                    if (!Tx_dataOut) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Resample half a bit later; a high line here is a glitch, not a frame
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (!Tx_dataOut) begin
                            DeStart_Bit <= 1'b1;
                            rx_bit_cnt  <= '0;
                            rx_state    <= ST_DATA;
                        end else begin
                            rx_state    <= ST_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt     <= '0;
                        Shift1     <= 1'b1;
                        Rx_data    <= {Tx_dataOut, Rx_data[31:1]};
                        rx_bit_cnt <= rx_bit_cnt + 1'b1;
                        if (rx_bit_cnt == 5'd31)
                            rx_state <= ST_PARITY;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt       <= '0;
                        Parity_Error <= (Tx_dataOut != word_parity(Rx_data));
                        rx_state     <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt     <= '0;
                        Check_Stop <= 1'b1;
                        Stop_Error <= ~Tx_dataOut;
                        rx_state   <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_top_module.sv
// tb/tb_uart_top_module.sv - directed loopback bench for uart_top_module at CLKS_PER_BIT=16
module tb_uart_top_module;
    localparam int N = 16;

    logic        Clock_In = 1'b0;
    logic        Reset;
    logic [31:0] Data_In;
    logic        Tx_start;
    logic        Tx_dataOut, Baud_Clk, Load, Shift, S0, S1, Data_Bit, Parity_Bit;
    logic        DeStart_Bit, Shift1, Check_Stop, Load1, Parity_Error, Stop_Error;
    logic [31:0] Rx_data, Rx_dataOut;

    uart_top_module #(.CLKS_PER_BIT(N)) dut (
        .Clock_In(Clock_In), .Reset(Reset), .Data_In(Data_In), .Tx_start(Tx_start),
        .Tx_dataOut(Tx_dataOut), .Baud_Clk(Baud_Clk), .Load(Load), .Shift(Shift),
        .S0(S0), .S1(S1), .Data_Bit(Data_Bit), .Parity_Bit(Parity_Bit),
        .DeStart_Bit(DeStart_Bit), .Shift1(Shift1), .Check_Stop(Check_Stop), .Load1(Load1),
        .Rx_data(Rx_data), .Rx_dataOut(Rx_dataOut),
        .Parity_Error(Parity_Error), .Stop_Error(Stop_Error)
    );

    always #5 Clock_In = ~Clock_In;

`ifdef UART_ODD_PARITY_EN
    localparam logic PAR_22C4 = 1'b0;
    localparam logic PAR_8001 = 1'b1;
`else
    localparam logic PAR_22C4 = 1'b1;
    localparam logic PAR_8001 = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ld_cnt, sh_cnt, l1_cnt, err_at_l1;
    logic [31:0] rxq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock_In);
        cyc++;
        if (Load) ld_cnt++;
        if (Shift) sh_cnt++;
        if (Load1) begin
            l1_cnt++;
            rxq.push_back(Rx_dataOut);
            if (Parity_Error || Stop_Error) err_at_l1++;
        end
    endtask

    task automatic wait_load(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (Load) ok = 1'b1;
        end
    endtask

    task automatic wait_load1(input int bound, output bit ok, output int lat);
        ok = 1'b0;
        lat = 0;
        while (lat < bound && !ok) begin
            step();
            lat++;
            if (Load1) ok = 1'b1;
        end
    endtask

    initial begin
        bit          ok;
        bit          line_low;
        int          lat, last_cyc, k;
        logic [34:0] line_tr;
        logic [1:0]  sel_tr[35];

        Reset = 1'b1; Tx_start = 1'b0; Data_In = '0;
        ld_cnt = 0; sh_cnt = 0; l1_cnt = 0; err_at_l1 = 0;
        repeat (3) @(negedge Clock_In);
        check("rst_line", 64'(Tx_dataOut), 64'd1);
        check("rst_rx_dataout", 64'(Rx_dataOut), 64'd0);
        check("rst_rx_data", 64'(Rx_data), 64'd0);
        check("rst_strobes", 64'({Baud_Clk, Load, Shift, S1, S0, Data_Bit, Parity_Bit, DeStart_Bit,
                                  Shift1, Check_Stop, Load1, Parity_Error, Stop_Error}), 64'd0);

        Reset = 1'b0;
        line_low = 1'b0;
        repeat (100) begin
            step();
            if (!Tx_dataOut) line_low = 1'b1;
        end
        check("idle_line_high", 64'(line_low), 64'd0);
        check("idle_no_load", 64'(ld_cnt), 64'd0);

        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin step(); ok = Baud_Clk; end
        check("baud_first_tick", 64'(ok), 64'd1);
        k = 0; ok = 1'b0;
        while (k < 40 && !ok) begin step(); k++; ok = Baud_Clk; end
        check("baud_period", 64'(k), 64'(N));

        // Single frame of 8900
        Data_In = 32'h0000_22C4; Tx_start = 1'b1;
        ld_cnt = 0; sh_cnt = 0; l1_cnt = 0; err_at_l1 = 0; rxq.delete();
        wait_load(40, ok);
        check("f1_load_seen", 64'(ok), 64'd1);
        Tx_start = 1'b0;
        check("f1_parity_bit", 64'(Parity_Bit), 64'(PAR_22C4));
        wait_load1(700, ok, lat);
        check("f1_load1_seen", 64'(ok), 64'd1);
        check("f1_latency", 64'(lat >= 550 && lat <= 560), 64'd1);
        check("f1_shift_count", 64'(sh_cnt), 64'd32);
        check("f1_load_count", 64'(ld_cnt), 64'd1);
        check("f1_rx_dataout", 64'(Rx_dataOut), 64'h22C4);
        check("f1_errors", 64'({Parity_Error, Stop_Error}), 64'd0);

        // Line and mux-select trace of 0x80000001, sampled mid-bit
        Data_In = 32'h8000_0001; Tx_start = 1'b1;
        wait_load(600, ok);
        check("tr_load_seen", 64'(ok), 64'd1);
        Tx_start = 1'b0;
        check("tr_parity_bit", 64'(Parity_Bit), 64'(PAR_8001));
        for (int b = 0; b < 35; b++) begin
            repeat ((b == 0) ? 1 + N / 2 : N) step();
            line_tr[b] = Tx_dataOut;
            sel_tr[b] = {S1, S0};
        end
        check("tr_line", 64'(line_tr), 64'({1'b1, PAR_8001, 1'b1, 30'b0, 1'b1, 1'b0}));
        check("tr_sel", 64'({sel_tr[0], sel_tr[1], sel_tr[32], sel_tr[33], sel_tr[34]}), 64'(10'b01_10_10_11_00));
        wait_load1(400, ok, lat);
        check("tr_load1_seen", 64'(ok), 64'd1);
        check("tr_rx_dataout", 64'(Rx_dataOut), 64'h8000_0001);
        check("tr_errors", 64'({Parity_Error, Stop_Error}), 64'd0);

        // Back-to-back frames 8900..8910 with Tx_start held high
        rxq.delete(); err_at_l1 = 0;
        Data_In = 32'd8900; Tx_start = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 11; i++) begin
            wait_load(600, ok);
            check($sformatf("b2b_load_%0d", i), 64'(ok), 64'd1);
            if (i > 0) check($sformatf("b2b_spacing_%0d", i), 64'(cyc - last_cyc), 64'(35 * N));
            last_cyc = cyc;
            if (i < 10) Data_In = 32'(8901 + i);
            else Tx_start = 1'b0;
        end
        k = 0;
        while (rxq.size() < 11 && k < 1200) begin step(); k++; end
        check("b2b_rx_count", 64'(rxq.size()), 64'd11);
        for (int i = 0; i < 11 && i < rxq.size(); i++)
            check($sformatf("b2b_rx_%0d", i), 64'(rxq[i]), 64'(8900 + i));
        check("b2b_errors", 64'(err_at_l1), 64'd0);

        // Reset in the middle of data bit 10
        Data_In = 32'h1234_5678; Tx_start = 1'b1;
        wait_load(600, ok);
        check("rs_load_seen", 64'(ok), 64'd1);
        Tx_start = 1'b0;
        repeat (1 + 11 * N + N / 2) step();
        check("rs_in_data", 64'({S1, S0}), 64'(2'b10));
        Reset = 1'b1;
        #1;
        check("rs_async_line", 64'(Tx_dataOut), 64'd1);
        check("rs_async_sel", 64'({S1, S0}), 64'd0);
        check("rs_async_rx", 64'({Rx_dataOut, Rx_data}), 64'd0);
        @(negedge Clock_In);
        Reset = 1'b0;
        l1_cnt = 0; line_low = 1'b0;
        repeat (40 * N) begin
            step();
            if (!Tx_dataOut) line_low = 1'b1;
        end
        check("rs_no_load1", 64'(l1_cnt), 64'd0);
        check("rs_line_idle", 64'(line_low), 64'd0);
        check("rs_rx_dataout", 64'(Rx_dataOut), 64'd0);

        Data_In = 32'hA5A5_0F0F; Tx_start = 1'b1;
        wait_load(40, ok);
        check("rs2_load_seen", 64'(ok), 64'd1);
        Tx_start = 1'b0;
        wait_load1(700, ok, lat);
        check("rs2_load1_seen", 64'(ok), 64'd1);
        check("rs2_rx_dataout", 64'(Rx_dataOut), 64'hA5A5_0F0F);
        check("rs2_errors", 64'({Parity_Error, Stop_Error}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
